div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit.sv | 147 ++++++++++++++
 tb/tb_div_unit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
//   32-bit signed integer divider. It uses restoring division on the operand
//   magnitudes and produces one quotient bit per cycle. The quotient and
//   remainder are then sign-corrected so that division truncates toward zero:
//   the quotient is negated when the operand signs differ, and the remainder
//   takes the sign of the dividend.
//   A zero divisor finishes in a single cycle. It returns quotient 0,
//   remainder 0 and sets the exception flag.
//
// Ports
//   clock           in   1   rising-edge clock for all state
//   reset           in   1   synchronous active-high reset
//   data_operandA   in  32   dividend, captured on an accepted start
//   data_operandB   in  32   divisor, captured on an accepted start
//   ctrl_DIV        in   1   start request, accepted in IDLE or DONE
//   data_result     out 32   quotient, held until the next completion
//   data_remainder  out 32   remainder, held until the next completion
//   data_exception  out  1   divide-by-zero flag, valid with data_resultRDY
//   data_resultRDY  out  1   high for exactly the one DONE cycle
// -----------------------------------------------------------------------------
module div_unit (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] data_operandA,
   input  logic [31:0] data_operandB,
   input  logic        ctrl_DIV,
   output logic [31:0] data_result,
   output logic [31:0] data_remainder,
   output logic        data_exception,
   output logic        data_resultRDY
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state, state_next;

   logic [4:0]  count;
   logic [31:0] dvd;        // dividend magnitude; quotient bits shift in at the LSB
   logic [31:0] dsr;        // divisor magnitude (0x80000000 means 2^31)
   logic [31:0] rem;        // partial remainder
   logic        neg_quo;
   logic        neg_rem;

   logic        start_ok;
   logic        div_zero;
   logic [32:0] trial;
   logic        qbit;
   logic [31:0] rem_step;
   logic [31:0] quo_step;
   logic [31:0] mag_a;
   logic [31:0] mag_b;

   // A start is accepted whenever no division is running. This includes DONE,
   // which allows back-to-back operations.
   assign start_ok = ctrl_DIV && (state != RUN);
   assign div_zero = (data_operandB == 32'd0);

   // Negating 0x80000000 gives 0x80000000 again. Read as unsigned, that is 2^31,
   // which is exactly the magnitude needed.
   assign mag_a = data_operandA[31] ? (32'd0 - data_operandA) : data_operandA;
   assign mag_b = data_operandB[31] ? (32'd0 - data_operandB) : data_operandB;

   // One restoring step. The remainder stays below the divisor, and the divisor
   // is at most 2^31, so the shifted remainder always fits in 32 bits.
   assign trial    = {rem, dvd[31]} - {1'b0, dsr};
   assign qbit     = ~trial[32];
   assign rem_step = qbit ? trial[31:0] : {rem[30:0], dvd[31]};
   assign quo_step = {dvd[30:0], qbit};

   assign data_resultRDY = (state == DONE);

   // NOTE: sequential state uses non-blocking assignments only. Every flop then
   // samples values from before the edge, so process order cannot change results.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // NOTE: state_next gets its default before the case statement. A path that
   // leaves it unassigned would otherwise infer a latch.
   always_comb begin
      state_next = state;
      case (state)
         IDLE, DONE: begin
            if (ctrl_DIV) begin
               state_next = div_zero ? DONE : RUN;
            end else begin
               state_next = IDLE;
            end
         end
         RUN: begin
            if (count == 5'd31) begin
               state_next = DONE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Control counter and visible outputs. These have defined reset values.
   always_ff @(posedge clock) begin
      if (reset) begin
         count          <= 5'd0;
         data_result    <= 32'd0;
         data_remainder <= 32'd0;
         data_exception <= 1'b0;
      end else if (start_ok) begin
         count <= 5'd0;
         if (div_zero) begin
            data_result    <= 32'd0;
            data_remainder <= 32'd0;
            data_exception <= 1'b1;
         end
      end else if (state == RUN) begin
         count <= count + 5'd1;
         if (count == 5'd31) begin
            data_result    <= neg_quo ? (32'd0 - quo_step) : quo_step;
            data_remainder <= neg_rem ? (32'd0 - rem_step) : rem_step;
            data_exception <= 1'b0;
         end
      end
   end

   // NOTE: the working datapath registers get no reset. Every accepted start
   // loads them before RUN reads them, and reset can only lead back to IDLE.
   always_ff @(posedge clock) begin
      if (start_ok) begin
         dvd     <= mag_a;
         dsr     <= mag_b;
         rem     <= 32'd0;
         neg_quo <= data_operandA[31] ^ data_operandB[31];
         neg_rem <= data_operandA[31];
      end else if (state == RUN) begin
         dvd <= quo_step;
         rem <= rem_step;
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// -----------------------------------------------------------------------------
// tb_div_unit
//   Directed, table-driven bench for div_unit. Each vector holds the operands,
//   the hand-computed quotient, remainder and exception, and the expected cycle
//   at which data_resultRDY goes high (counted from the start edge). Separate
//   hand-written sequences cover a start pulse during RUN, back-to-back
//   operation from DONE, and reset in the middle of RUN.
// -----------------------------------------------------------------------------
module tb_div_unit;

   logic        clock;
   logic        reset;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        start;
   logic [31:0] result;
   logic [31:0] remainder;
   logic        exc;
   logic        rdy;

   int n_checks = 0;
   int n_fail   = 0;

   div_unit dut (
      .clock          (clock),
      .reset          (reset),
      .data_operandA  (op_a),
      .data_operandB  (op_b),
      .ctrl_DIV       (start),
      .data_result    (result),
      .data_remainder (remainder),
      .data_exception (exc),
      .data_resultRDY (rdy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] q;
      logic [31:0] r;
      logic        e;
      int          lat;
   } vec_t;

   task automatic check(input string name, input logic [31:0] actual,
                        input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   // Sets up the operands before a rising edge and drops the start request
   // afterwards. The operand inputs are then overwritten with junk values, so
   // any late sampling of them would corrupt the result. Returns at the
   // falling edge one cycle after the start edge.
   task automatic do_start(input logic [31:0] a, input logic [31:0] b);
      @(negedge clock);
      op_a  = a;
      op_b  = b;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      op_a  = 32'hDEAD_BEEF;
      op_b  = 32'h0000_0000;
   endtask

   // Counts falling edges until rdy goes high. Gives up after a bounded
   // budget; a late result then shows up as a latency mismatch.
   task automatic wait_rdy(input int c0, output int cyc);
      cyc = c0;
      while (!rdy && cyc < 100) begin
         @(negedge clock);
         cyc++;
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int cyc;
      do_start(v.a, v.b);
      wait_rdy(1, cyc);
      check($sformatf("v%0d latency", idx), 32'(cyc), 32'(v.lat));
      check($sformatf("v%0d quotient", idx), result, v.q);
      check($sformatf("v%0d remainder", idx), remainder, v.r);
      check($sformatf("v%0d exception", idx), {31'd0, exc}, {31'd0, v.e});
      @(negedge clock);
      check($sformatf("v%0d rdy one cycle", idx), {31'd0, rdy}, 32'd0);
   endtask

   vec_t vecs[12];

   initial begin
      int cyc;
      int pulses;

      vecs[0]  = '{32'd100,      32'd7,        32'd14,       32'd2,        1'b0, 33};
      vecs[1]  = '{-32'sd100,    32'd7,        32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 33};
      vecs[2]  = '{32'd100,      -32'sd7,      32'hFFFF_FFF2, 32'd2,        1'b0, 33};
      vecs[3]  = '{32'd5,        32'd0,        32'd0,        32'd0,        1'b1, 1};
      vecs[4]  = '{32'd9,        32'd3,        32'd3,        32'd0,        1'b0, 33};
      vecs[5]  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,      1'b0, 33};
      vecs[6]  = '{32'h8000_0000, 32'd1,        32'h8000_0000, 32'd0,        1'b0, 33};
      vecs[7]  = '{-32'sd7,      -32'sd2,      32'd3,        32'hFFFF_FFFF, 1'b0, 33};
      vecs[8]  = '{32'd0,        32'd5,        32'd0,        32'd0,        1'b0, 33};
      vecs[9]  = '{32'hFFFF_FFFF, 32'h8000_0000, 32'd0,       32'hFFFF_FFFF, 1'b0, 33};
      vecs[10] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001, 32'd0,      1'b0, 33};
      vecs[11] = '{32'hFFFF_FFFF, 32'd0,        32'd0,        32'd0,        1'b1, 1};

      reset = 1'b1;
      start = 1'b1;            // reset must override a start request
      op_a  = 32'd10;
      op_b  = 32'd2;
      repeat (3) @(negedge clock);
      check("reset rdy", {31'd0, rdy}, 32'd0);
      check("reset result", result, 32'd0);
      check("reset remainder", remainder, 32'd0);
      check("reset exception", {31'd0, exc}, 32'd0);
      start = 1'b0;
      reset = 1'b0;

      for (int i = 0; i < 12; i++) begin
         run_vec(vecs[i], i);
      end

      // A start pulse with 1 / 1 at RUN cycle 10 of 50 / 5 must be ignored.
      do_start(32'd50, 32'd5);
      repeat (9) @(negedge clock);
      op_a  = 32'd1;
      op_b  = 32'd1;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      wait_rdy(11, cyc);
      check("busy latency", 32'(cyc), 32'd33);
      check("busy quotient", result, 32'd10);
      check("busy remainder", remainder, 32'd0);

      // Back-to-back start from DONE: the current outputs stay valid in this
      // cycle, and 8 / 2 then completes 33 cycles later.
      op_a  = 32'd8;
      op_b  = 32'd2;
      start = 1'b1;
      check("b2b held result", result, 32'd10);
      @(negedge clock);
      start = 1'b0;
      op_a  = 32'd3;
      op_b  = 32'd3;
      check("b2b rdy drops", {31'd0, rdy}, 32'd0);
      check("b2b result holds", result, 32'd10);
      wait_rdy(1, cyc);
      check("b2b latency", 32'(cyc), 32'd33);
      check("b2b quotient", result, 32'd4);
      check("b2b exception", {31'd0, exc}, 32'd0);
      @(negedge clock);

      // Reset at RUN cycle 20 aborts the division without any rdy pulse.
      do_start(32'd1000, 32'd3);
      repeat (19) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check("abort result", result, 32'd0);
      check("abort remainder", remainder, 32'd0);
      check("abort exception", {31'd0, exc}, 32'd0);
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         if (rdy) pulses++;
         @(negedge clock);
      end
      check("abort no pulse", 32'(pulses), 32'd0);

      // The first start after reset must be accepted normally.
      do_start(32'd7, 32'd7);
      wait_rdy(1, cyc);
      check("post-reset latency", 32'(cyc), 32'd33);
      check("post-reset quotient", result, 32'd1);
      check("post-reset remainder", remainder, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
